// File: rtl/rat_pkg.sv
// Shared types for the rat maze solver and its path checker.
// move_t is the move encoding on the solver-to-checker Move stream.
package rat_pkg;

  typedef enum logic [1:0] {
    MV_XP = 2'b00,
    MV_YN = 2'b01,
    MV_XN = 2'b10,
    MV_YP = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_WALL = 2'b01,
    FC_OOB  = 2'b10,
    FC_END  = 2'b11
  } fail_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_READ,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } chk_state_t;

endpackage

// File: rtl/rat_pos_step.sv
// One maze step: applies a move to a position and flags any carry or borrow
// out of the CW-bit coordinate as leaving the maze.
module rat_pos_step
  import rat_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  move_t         move_i,
  output logic [CW-1:0] nx_o,
  output logic [CW-1:0] ny_o,
  output logic          oob_o
);

  localparam logic [CW:0] ONE = (CW+1)'(1);

  logic [CW:0] xe;
  logic [CW:0] ye;

  always_comb begin
    xe = {1'b0, x_i};
    ye = {1'b0, y_i};
    unique case (move_i)
      MV_XP: xe = {1'b0, x_i} + ONE;
      MV_YN: ye = {1'b0, y_i} - ONE;
      MV_XN: xe = {1'b0, x_i} - ONE;
      MV_YP: ye = {1'b0, y_i} + ONE;
    endcase
    nx_o  = xe[CW-1:0];
    ny_o  = ye[CW-1:0];
    oob_o = xe[CW] | ye[CW];
  end

endmodule

// File: rtl/rat_path_checker.sv
// Replays the solver's move stream against the maze memory and scores the path:
// accepted when it avoids walls, stays in bounds and stops on the goal cell.
module rat_path_checker
  import rat_pkg::*;
#(
  parameter int CW      = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15,
  parameter int STEP_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Move_valid,
  input  logic [1:0]        Move,
  input  logic              Move_last,
  output logic              Move_ready,
  output logic              Mem_rd,
  output logic [CW-1:0]     Mem_X,
  output logic [CW-1:0]     Mem_Y,
  input  logic              Mem_dout,
  output logic              Busy,
  output logic              Done,
  output logic              Fail,
  output logic [1:0]        Fail_code,
  output logic [STEP_W-1:0] Steps
);

  localparam logic [CW-1:0]     START_XC = CW'(START_X);
  localparam logic [CW-1:0]     START_YC = CW'(START_Y);
  localparam logic [CW-1:0]     GOAL_XC  = CW'(GOAL_X);
  localparam logic [CW-1:0]     GOAL_YC  = CW'(GOAL_Y);
  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  chk_state_t        state_q;
  logic [CW-1:0]     pos_x_q, pos_y_q;
  logic [CW-1:0]     nxt_x_q, nxt_y_q;
  logic              last_q;
  logic [STEP_W-1:0] steps_q;
  logic              ready_q, rd_q, busy_q, done_q, fail_q;
  fail_code_t        code_q;
  logic [CW-1:0]     mem_x_q, mem_y_q;

  logic [CW-1:0]     nx_d, ny_d;
  logic              oob_d;

  rat_pos_step #(.CW(CW)) u_step (
    .x_i    (pos_x_q),
    .y_i    (pos_y_q),
    .move_i (move_t'(Move)),
    .nx_o   (nx_d),
    .ny_o   (ny_d),
    .oob_o  (oob_d)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      pos_x_q <= START_XC;
      pos_y_q <= START_YC;
      nxt_x_q <= '0;
      nxt_y_q <= '0;
      last_q  <= 1'b0;
      steps_q <= '0;
      ready_q <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= FC_NONE;
      mem_x_q <= '0;
      mem_y_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (Start) begin
            state_q <= ST_INIT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= FC_NONE;
          end
        end
        ST_INIT: begin
          pos_x_q <= START_XC;
          pos_y_q <= START_YC;
          steps_q <= '0;
          ready_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Move_valid) begin
            nxt_x_q <= nx_d;
            nxt_y_q <= ny_d;
            last_q  <= Move_last;
            ready_q <= 1'b0;
            if (oob_d) begin
              code_q  <= FC_OOB;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FAIL;
            end else begin
              rd_q    <= 1'b1;
              mem_x_q <= nx_d;
              mem_y_q <= ny_d;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          rd_q    <= 1'b0;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (Mem_dout) begin
            code_q  <= FC_WALL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FAIL;
          end else begin
            pos_x_q <= nxt_x_q;
            pos_y_q <= nxt_y_q;
            // A path that overruns the counter is rejected; Steps saturates instead of wrapping.
            if (steps_q == STEP_MAX) begin
              code_q  <= FC_END;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FAIL;
            end else begin
              steps_q <= steps_q + STEP_ONE;
              if (last_q) begin
                busy_q <= 1'b0;
                if (nxt_x_q == GOAL_XC && nxt_y_q == GOAL_YC) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  code_q  <= FC_END;
                  fail_q  <= 1'b1;
                  state_q <= ST_FAIL;
                end
              end else begin
                ready_q <= 1'b1;
                state_q <= ST_WAIT;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Move_ready = ready_q;
  assign Mem_rd     = rd_q;
  assign Mem_X      = mem_x_q;
  assign Mem_Y      = mem_y_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Fail       = fail_q;
  assign Fail_code  = code_q;
  assign Steps      = steps_q;

endmodule
